// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle sequencer and the datapath/memory.
// The sequencer takes the slave view; the datapath (or a bench) takes the master view.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             mem_read;
  logic             mem_write;
  logic             i_or_d;
  logic             ir_write;
  logic             pc_write;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             mem_to_reg;
  logic             illegal;
  logic             timeout;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] instr_count;

  modport slave (
    input  stall, opcode, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_write, alu_src, alu_op,
           reg_write, mem_to_reg, illegal, timeout, state_o, instr_count
  );

  modport master (
    output stall, opcode, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_write, alu_src, alu_op,
           reg_write, mem_to_reg, illegal, timeout, state_o, instr_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the simple RISC-V core: steps fetch, decode, execute,
// address, memory and writeback over a shared single-port memory and ALU.
// Handles R-type, addi, load and store; traps on illegal opcodes and memory timeouts.
// Strobes are decoded from the current state (plus the fetch-complete Mealy terms).
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_controller_if.slave bus
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_ADDR   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OP_R     = 2'd0,
    OP_I     = 2'd1,
    OP_LOAD  = 2'd2,
    OP_STORE = 2'd3
  } op_t;

  state_t           stateQ, stateD;
  op_t              opQ, opD;
  logic [WAIT_W-1:0] waitQ, waitD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic             illegalQ, illegalD;
  logic             timeoutQ, timeoutD;

  logic       memRead, memWrite, iOrD, irWrite, pcWrite, aluSrc, regWrite, memToReg;
  logic [1:0] aluOp;

  // State, decoded-op, wait counter, retire counter and sticky trap flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= S_FETCH;
      opQ      <= OP_R;
      waitQ    <= '0;
      cntQ     <= '0;
      illegalQ <= 1'b0;
      timeoutQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      opQ      <= opD;
      waitQ    <= waitD;
      cntQ     <= cntD;
      illegalQ <= illegalD;
      timeoutQ <= timeoutD;
    end
  end

  // Next-state logic; a stall freezes everything, TRAP ignores stall and never leaves.
  always_comb begin
    stateD   = stateQ;
    opD      = opQ;
    waitD    = waitQ;
    cntD     = cntQ;
    illegalD = illegalQ;
    timeoutD = timeoutQ;

    if (!bus.stall) begin
      unique case (stateQ)
        S_FETCH: begin
          if (bus.mem_ready) begin
            stateD = S_DECODE;
          end else if (waitQ == WAIT_LAST) begin
            stateD   = S_TRAP;
            timeoutD = 1'b1;
          end else begin
            waitD = waitQ + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          unique case (bus.opcode)
            OPC_R:     begin opD = OP_R;     stateD = S_EXEC; end
            OPC_I:     begin opD = OP_I;     stateD = S_EXEC; end
            OPC_LOAD:  begin opD = OP_LOAD;  stateD = S_ADDR; end
            OPC_STORE: begin opD = OP_STORE; stateD = S_ADDR; end
            default: begin
              stateD   = S_TRAP;
              illegalD = 1'b1;
            end
          endcase
        end
        S_EXEC: stateD = S_WB;
        S_ADDR: stateD = S_MEM;
        S_MEM: begin
          if (bus.mem_ready) begin
            if (opQ == OP_STORE) begin
              stateD = S_FETCH;
              cntD   = cntQ + CNT_W'(1);
            end else begin
              stateD = S_WB;
            end
          end else if (waitQ == WAIT_LAST) begin
            stateD   = S_TRAP;
            timeoutD = 1'b1;
          end else begin
            waitD = waitQ + WAIT_W'(1);
          end
        end
        S_WB: begin
          stateD = S_FETCH;
          cntD   = cntQ + CNT_W'(1);
        end
        S_TRAP: stateD = S_TRAP;
        default: stateD = S_FETCH;
      endcase
    end

    // Wait counter measures consecutive waits within one state only.
    if (stateD != stateQ) begin
      waitD = '0;
    end
  end

  // Strobe decode from state/op; stall masks the side-effecting strobes, reset masks all.
  always_comb begin
    memRead  = 1'b0;
    memWrite = 1'b0;
    iOrD     = 1'b0;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    aluSrc   = 1'b0;
    aluOp    = 2'b00;
    regWrite = 1'b0;
    memToReg = 1'b0;

    unique case (stateQ)
      S_FETCH: begin
        memRead = 1'b1;
        if (bus.mem_ready && !bus.stall) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
        end
      end
      S_EXEC: begin
        aluSrc = (opQ == OP_I);
        aluOp  = (opQ == OP_I) ? 2'b00 : 2'b10;
      end
      S_ADDR: begin
        aluSrc = 1'b1;
        aluOp  = 2'b01;
      end
      S_MEM: begin
        iOrD     = 1'b1;
        aluSrc   = 1'b1;
        aluOp    = 2'b01;
        memRead  = (opQ == OP_LOAD);
        memWrite = (opQ == OP_STORE);
      end
      S_WB: begin
        regWrite = 1'b1;
        memToReg = (opQ == OP_LOAD);
      end
      default: ;
    endcase

    if (bus.stall) begin
      irWrite  = 1'b0;
      pcWrite  = 1'b0;
      regWrite = 1'b0;
      memWrite = 1'b0;
    end

    if (!rst_n) begin
      memRead  = 1'b0;
      memWrite = 1'b0;
      iOrD     = 1'b0;
      irWrite  = 1'b0;
      pcWrite  = 1'b0;
      aluSrc   = 1'b0;
      aluOp    = 2'b00;
      regWrite = 1'b0;
      memToReg = 1'b0;
    end
  end

  assign bus.mem_read    = memRead;
  assign bus.mem_write   = memWrite;
  assign bus.i_or_d      = iOrD;
  assign bus.ir_write    = irWrite;
  assign bus.pc_write    = pcWrite;
  assign bus.alu_src     = aluSrc;
  assign bus.alu_op      = aluOp;
  assign bus.reg_write   = regWrite;
  assign bus.mem_to_reg  = memToReg;
  assign bus.illegal     = illegalQ;
  assign bus.timeout     = timeoutQ;
  assign bus.state_o     = stateQ;
  assign bus.instr_count = cntQ;

endmodule
